// File: rtl/round_pkg.sv
// Shared definitions for the rounding-apply pipeline: rounding-mode encoding,
// representative field positions and default widths.
package round_pkg;

    // Default widths of the representative input and rounded output.
    localparam int DEF_W_IN  = 55;
    localparam int DEF_W_OUT = 53;
    localparam int DEF_CNT_W = 32;

    // Field positions inside the representative significand.
    localparam int DB_G         = 1;   // double: guard bit
    localparam int SG_G         = 30;  // single: guard bit
    localparam int SG_STICKY_LO = 0;   // single: sticky OR range, low end
    localparam int SG_STICKY_HI = 29;  // single: sticky OR range, high end

    // IEEE rounding modes as encoded on the rm input.
    typedef enum logic [1:0] {
        RM_RNE  = 2'b00,
        RM_RZ   = 2'b01,
        RM_PINF = 2'b10,
        RM_NINF = 2'b11
    } rm_t;

endpackage

// File: rtl/round_decide.sv
// Combinational rounding decision: given the retained lsb, guard, sticky,
// rounding mode and sign, decide whether to increment and whether the result
// is inexact.
module round_decide
    import round_pkg::*;
(
    input  logic lsb,
    input  logic g,
    input  logic s,
    input  rm_t  rm,
    input  logic sign,
    output logic inc,
    output logic inexact
);

    // Apply the IEEE increment rule for the selected rounding mode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the block can leave it unassigned (no latch).
        inc     = 1'b0;
        inexact = g | s;
        unique case (rm)
            RM_RNE:  inc = g & (s | lsb);
            RM_RZ:   inc = 1'b0;
            RM_PINF: inc = ~sign & (g | s);
            RM_NINF: inc = sign & (g | s);
        endcase
    end

endmodule

// File: rtl/round_apply.sv
// Rounding apply and post-normalization, two-stage valid/ready pipeline.
// S1 captures the left-aligned significand and rounding decision, S2 holds the
// rounded significand, carry-out and inexact flag presented to the consumer.
// Optional feature macro: ROUND_STATS_EN adds saturating inexact/carry counters.
module round_apply
    import round_pkg::*;
#(
    parameter int W_IN  = DEF_W_IN,
    parameter int W_OUT = DEF_W_OUT
`ifdef ROUND_STATS_EN
    ,
    parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  f1,
    input  logic             db,
    input  logic [1:0]       rm,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] fr,
    output logic             carry,
    output logic             inexact
`ifdef ROUND_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] inexact_cnt,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    // Single-precision significand width and the zero padding below it once
    // left-aligned into the output width.
    localparam int SG_W   = W_IN - 1 - SG_G;
    localparam int SG_PAD = W_OUT - SG_W;
    // Double-precision significand occupies the top W_OUT bits of f1.
    localparam int DB_LO  = W_IN - W_OUT;

    // Field extraction results.
    logic [W_OUT-1:0] sig_in;
    logic             lsb_in;
    logic             g_in;
    logic             s_in;
    logic             inc_in;
    logic             inexact_in;
    rm_t              rm_e;

    // Handshake terms.
    logic s2_adv;
    logic move;
    logic accept;

    // Stage 1 registers.
    logic             s1_v_q,       s1_v_d;
    logic [W_OUT-1:0] s1_sig_q,     s1_sig_d;
    logic             s1_inc_q,     s1_inc_d;
    logic             s1_inexact_q, s1_inexact_d;
    logic             s1_db_q,      s1_db_d;

    // Stage 2 registers.
    logic             s2_v_q,       s2_v_d;
    logic [W_OUT-1:0] fr_q,         fr_d;
    logic             carry_q,      carry_d;
    logic             inexact_q,    inexact_d;

    // Rounded sum with one extra bit to catch the carry-out.
    logic [W_OUT:0]   inc_vec;
    logic [W_OUT:0]   sum;

    assign rm_e = rm_t'(rm);

    // Split the representative into significand, guard and sticky by precision.
    always_comb begin
        sig_in = '0;
        lsb_in = 1'b0;
        g_in   = 1'b0;
        s_in   = 1'b0;
        if (db) begin
            sig_in = f1[W_IN-1:DB_LO];
            lsb_in = f1[DB_LO];
            g_in   = f1[DB_G];
            s_in   = f1[0];
        end else begin
            sig_in = {f1[W_IN-1:SG_G+1], {SG_PAD{1'b0}}};
            lsb_in = f1[SG_G+1];
            g_in   = f1[SG_G];
            s_in   = |f1[SG_STICKY_HI:SG_STICKY_LO];
        end
    end

    round_decide u_decide (
        .lsb     (lsb_in),
        .g       (g_in),
        .s       (s_in),
        .rm      (rm_e),
        .sign    (sign),
        .inc     (inc_in),
        .inexact (inexact_in)
    );

    // Each stage advances when the slot after it is empty or being drained.
    always_comb begin
        s2_adv   = ~s2_v_q | out_ready;
        move     = s1_v_q & s2_adv;
        in_ready = ~s1_v_q | s2_adv;
        accept   = in_valid & in_ready;
        s1_v_d   = accept | (s1_v_q & ~s2_adv);
        s2_v_d   = s2_adv ? s1_v_q : s2_v_q;
    end

    // S1 captures a new beat only on accept; otherwise it holds.
    always_comb begin
        s1_sig_d     = s1_sig_q;
        s1_inc_d     = s1_inc_q;
        s1_inexact_d = s1_inexact_q;
        s1_db_d      = s1_db_q;
        if (accept) begin
            s1_sig_d     = sig_in;
            s1_inc_d     = inc_in;
            s1_inexact_d = inexact_in;
            s1_db_d      = db;
        end
    end

    // Add the increment at the precision's lsb and renormalize on overflow.
    always_comb begin
        inc_vec = '0;
        if (s1_inc_q) begin
            if (s1_db_q) inc_vec[0]      = 1'b1;
            else         inc_vec[SG_PAD] = 1'b1;
        end
        sum       = {1'b0, s1_sig_q} + inc_vec;
        fr_d      = fr_q;
        carry_d   = carry_q;
        inexact_d = inexact_q;
        if (move) begin
            carry_d   = sum[W_OUT];
            fr_d      = sum[W_OUT] ? {1'b1, {(W_OUT-1){1'b0}}} : sum[W_OUT-1:0];
            inexact_d = s1_inexact_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset too, because the outputs must
            // read as zero right after reset, not only the valid bits.
            s1_v_q       <= 1'b0;
            s1_sig_q     <= '0;
            s1_inc_q     <= 1'b0;
            s1_inexact_q <= 1'b0;
            s1_db_q      <= 1'b0;
            s2_v_q       <= 1'b0;
            fr_q         <= '0;
            carry_q      <= 1'b0;
            inexact_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            s1_v_q       <= s1_v_d;
            s1_sig_q     <= s1_sig_d;
            s1_inc_q     <= s1_inc_d;
            s1_inexact_q <= s1_inexact_d;
            s1_db_q      <= s1_db_d;
            s2_v_q       <= s2_v_d;
            fr_q         <= fr_d;
            carry_q      <= carry_d;
            inexact_q    <= inexact_d;
        end
    end

    assign out_valid = s2_v_q;
    assign fr        = fr_q;
    assign carry     = carry_q;
    assign inexact   = inexact_q;

`ifdef ROUND_STATS_EN
    logic             out_fire;
    logic [CNT_W-1:0] inexact_cnt_q, inexact_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q,   carry_cnt_d;

    // Count flagged results on each output handshake, saturating at all-ones.
    always_comb begin
        out_fire      = s2_v_q & out_ready;
        inexact_cnt_d = inexact_cnt_q;
        carry_cnt_d   = carry_cnt_q;
        if (stats_clr) begin
            inexact_cnt_d = '0;
            carry_cnt_d   = '0;
        end else if (out_fire) begin
            if (inexact_q && (inexact_cnt_q != '1)) inexact_cnt_d = inexact_cnt_q + 1'b1;
            if (carry_q && (carry_cnt_q != '1))     carry_cnt_d   = carry_cnt_q + 1'b1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inexact_cnt_q <= '0;
            carry_cnt_q   <= '0;
        end else begin
            inexact_cnt_q <= inexact_cnt_d;
            carry_cnt_q   <= carry_cnt_d;
        end
    end

    assign inexact_cnt = inexact_cnt_q;
    assign carry_cnt   = carry_cnt_q;
`else
    // Without statistics the output handshake needs no local bookkeeping.
`endif

endmodule

// File: tb/tb_round_apply.sv
// Self-checking bench for round_apply: randomized and directed beats feed a
// reference model whose results queue up; a monitor pops and compares on each
// output handshake and checks that stalled outputs hold steady.
// Optional feature macro: ROUND_STATS_EN (statistics counters).
module tb_round_apply;

    typedef struct packed {
        logic [52:0] fr;
        logic        carry;
        logic        inexact;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [54:0] f1 = '0;
    logic        db = 1'b0;
    logic [1:0]  rm = 2'b00;
    logic        sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [52:0] fr;
    logic        carry;
    logic        inexact;
`ifdef ROUND_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] inexact_cnt;
    logic [31:0] carry_cnt;
    int unsigned m_inx = 0;
    int unsigned m_car = 0;
`endif

    int   total = 0;
    int   bad = 0;
    int   accepted = 0;
    exp_t sb[$];
    bit   rand_ready = 1'b0;
    bit   held = 1'b0;
    exp_t held_val;

    round_apply dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f1        (f1),
        .db        (db),
        .rm        (rm),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fr        (fr),
        .carry     (carry),
        .inexact   (inexact)
`ifdef ROUND_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .inexact_cnt (inexact_cnt),
        .carry_cnt   (carry_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: round the significand as an integer of the precision's width.
    function automatic exp_t model(input logic [54:0] f, input logic d,
                                   input logic [1:0] m, input logic sg);
        exp_t            e;
        longint unsigned sig;
        longint unsigned res;
        bit              g, s, inc;
        int              width;
        if (d) begin
            sig = 64'(f[54:2]); g = f[1]; s = f[0]; width = 53;
        end else begin
            sig = 64'(f[54:31]); g = f[30]; s = |f[29:0]; width = 24;
        end
        case (m)
            2'd0:    inc = g && (s || sig[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = !sg && (g || s);
            default: inc = sg && (g || s);
        endcase
        res = sig + 64'(inc);
        e.carry = (res >> width) != 0;
        if (e.carry) res = 64'd1 << (width - 1);
        e.fr = 53'(res << (53 - width));
        e.inexact = g | s;
        return e;
    endfunction

    task automatic drive(input logic [54:0] f, input logic d, input logic [1:0] m, input logic sg);
        int waited = 0;
        bit acc;
        in_valid = 1'b1; f1 = f; db = d; rm = m; sign = sg;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sb.push_back(model(f, d, m, sg));
                accepted++;
                break;
            end
            waited++;
            if (waited > 500) begin
                total++; bad++;
                $display("FAIL accept_timeout: in_ready stuck low for %0d cycles", waited);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d beats still pending", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: hold stability while stalled, in-order compare on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held)
                check("hold_stable", {10'b0, out_valid, fr, carry, inexact}, {10'b0, 1'b1, held_val});
            if (out_valid) begin
                if (out_ready) begin
                    held = 1'b0;
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_output: fr=%0h with no beat pending", fr);
                    end else begin
                        e = sb.pop_front();
                        check("fr", 64'(fr), 64'(e.fr));
                        check("carry", 64'(carry), 64'(e.carry));
                        check("inexact", 64'(inexact), 64'(e.inexact));
`ifdef ROUND_STATS_EN
                        if (e.inexact) m_inx++;
                        if (e.carry)   m_car++;
`endif
                    end
                end else begin
                    held = 1'b1;
                    held_val = '{fr: fr, carry: carry, inexact: inexact};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Random downstream backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        logic [63:0] r;
        logic [54:0] f;

        // Reset state.
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fr", 64'(fr), 64'd0);
        check("rst_carry", 64'(carry), 64'd0);
        @(posedge clk);
        #1;

        // Double RNE tie to even, with latency check on an empty pipeline.
        drive({53'h0_1234_5678_9ABC, 1'b1, 1'b0}, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        check("lat_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2", 64'(out_valid), 64'd1);
        wait_drain();

        // Directed boundary cases.
        drive({53'h1F_FFFF_FFFF_FFFF, 1'b1, 1'b1}, 1'b1, 2'b00, 1'b0);
        drive({24'h800000, 1'b0, 30'h1}, 1'b0, 2'b10, 1'b0);
        drive({24'h9ABCDE, 1'b1, 30'h0}, 1'b0, 2'b11, 1'b0);
        drive({24'hFFFFFF, 1'b1, 30'h0}, 1'b0, 2'b00, 1'b0);
        drive({53'h0_0000_0000_0FFF, 1'b1, 1'b1}, 1'b1, 2'b01, 1'b1);
        drive({24'h123457, 1'b0, 30'h2000}, 1'b0, 2'b01, 1'b0);
        drive({53'h1F_FFFF_FFFF_FFFF, 1'b0, 1'b1}, 1'b1, 2'b11, 1'b1);
        wait_drain();

        // Backpressure: three beats offered, only two fit while stalled.
        out_ready = 1'b0;
        acc0 = accepted;
        fork
            begin
                drive({53'h0_0000_0000_0001, 1'b1, 1'b0}, 1'b1, 2'b00, 1'b0);
                drive({24'hABCDEF, 1'b1, 30'h5}, 1'b0, 2'b00, 1'b0);
                drive({53'h0_0000_0000_0003, 1'b1, 1'b0}, 1'b1, 2'b00, 1'b0);
            end
            begin
                repeat (8) @(negedge clk);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_held_count", 64'(accepted - acc0), 64'd2);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset while both stages hold a beat.
        out_ready = 1'b0;
        drive({53'h0_0000_0000_0010, 1'b1, 1'b1}, 1'b1, 2'b00, 1'b0);
        drive({24'h654321, 1'b1, 30'h0}, 1'b0, 2'b00, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
`ifdef ROUND_STATS_EN
        m_inx = 0;
        m_car = 0;
`endif
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_fr", 64'(fr), 64'd0);
        check("post_rst_inexact", 64'(inexact), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("no_stale_beat", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Randomized stream with random gaps and random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 5 == 0) begin
                @(posedge clk);
                #1;
            end
            r = {$urandom, $urandom};
            f = r[54:0];
            if ($urandom % 8 == 0) begin
                f[54:31] = '1;
                f[30] = 1'b1;
                f[2:0] = 3'b111;
                f[54:2] = (r[0]) ? '1 : f[54:2];
            end
            drive(f, 1'($urandom), 2'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();

`ifdef ROUND_STATS_EN
        @(negedge clk);
        check("stats_inexact_cnt", 64'(inexact_cnt), 64'(m_inx));
        check("stats_carry_cnt", 64'(carry_cnt), 64'(m_car));
        @(posedge clk);
        #1 stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        check("stats_clr_inexact", 64'(inexact_cnt), 64'd0);
        check("stats_clr_carry", 64'(carry_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
